io_serial_port: RTL and testbench
=================================

# io_serial_port

Serial I/O front-end for the basic-computer datapath. It deserialises an 8N1 receive line into INPR and raises FGI. It also serialises OUTR onto a transmit line and drops/raises FGO around each transfer. Upstream of the datapath's `datain` and downstream of its `dataout`, it implements the INP/OUT/SKI/SKO flag handshake.

## Interface
- `WIDTH`, 8, character width (matches datapath INPR/OUTR width)
- `CLKS_PER_BIT`, 16, CLK cycles per serial bit; must be even and ≥ 4
- `CLK`  in  1  rising-edge clock
- `RST_N`  in  1  reset, synchronous, active-low
- `rx`  in  1  serial input, idle high, asynchronous to CLK
- `tx`  out  1  serial output, idle high
- `inpr`  out  WIDTH  last accepted received character, to datapath `datain`
- `fgi`  out  1  input flag: new character available
- `inp_ack`  in  1  one-cycle pulse on INP execution; clears FGI
- `outr`  in  WIDTH  character from datapath `dataout`
- `out_load`  in  1  one-cycle pulse on OUT execution; captures `outr`
- `fgo`  out  1  output flag: transmitter ready
- `rx_overrun`  out  1  sticky: byte completed while FGI=1
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low
- `parity_err`  out  1  one-cycle pulse: parity mismatch (see Configuration)

## Operation
- Reset values:
  - `tx`=1, `inpr`=0, `fgi`=0, `fgo`=1.
  - `rx_overrun`=0, `frame_err`=0, `parity_err`=0.
  - Both FSMs return to IDLE.
  - Reset mid-frame aborts the frame; `tx` is high on the first edge with RST_N low.
- RX FSM: RX_IDLE → RX_START → RX_DATA → [RX_PARITY] → RX_STOP → RX_IDLE.
  - `rx` passes through a 2-flop synchroniser before use.
  - RX_IDLE: a synchronised falling edge starts the bit counter.
  - RX_START: samples at `CLKS_PER_BIT/2`. If the sample is high (glitch), return to RX_IDLE.
  - RX_DATA: takes WIDTH samples at full-bit intervals, LSB first.
  - RX_STOP: samples the stop bit.
    - Stop bit low: pulse `frame_err`, discard the byte, leave FGI unchanged.
    - Stop bit high, FGI=0: `inpr`←byte and `fgi`←1 on the next edge.
    - Stop bit high, FGI=1: set `rx_overrun`; `inpr` is not overwritten.
    - Stop bit high and `inp_ack` in the same cycle: the new byte is loaded, `fgi` stays 1, no overrun.
  - `inp_ack` with FGI=0 has no effect.
  - `rx_overrun` clears only on reset.
- TX FSM: TX_IDLE → TX_START → TX_DATA → [TX_PARITY] → TX_STOP → TX_IDLE.
  - `out_load` while `fgo`=1: capture `outr` into the shift register; `fgo`←0 on the same edge.
  - `out_load` while `fgo`=0: ignored; the character is dropped.
  - Frame: start bit low, WIDTH data bits LSB first, stop bit high. Each bit lasts CLKS_PER_BIT cycles.
  - `fgo`←1 on the edge ending the stop bit; TX_IDLE is entered on that edge.
- Bit counters wrap at CLKS_PER_BIT−1. Data-bit index counts 0..WIDTH−1.

## Timing
- TX: `tx` goes low on the edge after the `out_load` edge.
- TX: `fgo` rises (WIDTH+2)·CLKS_PER_BIT cycles after the `out_load` edge, i.e. 160 at defaults. Add CLKS_PER_BIT with parity enabled.
- TX: a new `out_load` is accepted in the same cycle `fgo` is seen high. Back-to-back frames therefore have no idle gap.
- RX: `fgi` rises 2 (synchroniser) + CLKS_PER_BIT/2 + (WIDTH+1)·CLKS_PER_BIT + 1 cycles after the `rx` falling edge at the pin. That is 155 at defaults, +CLKS_PER_BIT with parity.
- RX: `fgi` falls on the edge after `inp_ack`.
- RX: `frame_err` and `parity_err` are single-cycle pulses, coincident with the cycle FGI would have risen.

## Configuration
- `IO_SERIAL_PARITY_EN` defined:
  - An even-parity bit follows the data bits on both RX and TX.
  - RX mismatch pulses `parity_err`, discards the byte and leaves FGI unchanged.
  - The TX_PARITY and RX_PARITY states exist.
- Not defined:
  - 8N1 only; the parity states are absent.
  - `parity_err` is tied 0.

## Structure
- Package `io_serial_pkg`:
  - `rx_state_t` and `tx_state_t` enums.
  - `IO_STOP_BITS` = 1.
  - Reset constants `FGO_RST` = 1 and `FGI_RST` = 0.
- One sub-module, `io_bit_timer`:
  - Parameterised down-counter with `start` (half or full period) and `tick` output.
  - Instantiated once for RX and once for TX.
- All flags live in the top level.

## Test plan
1. Reset: hold RST_N=0 for 3 cycles → `tx`=1, `fgo`=1, `fgi`=0, `inpr`=0x00, all error outputs 0.
2. Transmit: `out_load` with `outr`=0xA5 → `fgo`=0 next cycle; `tx` shows bits 0,1,0,1,0,0,1,0,1,1 at 16 cycles each; `fgo`=1 exactly 160 cycles after load.
3. Receive: drive an 8N1 frame of 0x3C on `rx` → `inpr`=0x3C and `fgi`=1 at cycle 155; `inp_ack` → `fgi`=0 next cycle; `inpr` holds 0x3C.
4. Overrun: receive 0x11, do not ack, receive 0x22 → `inpr`=0x11, `rx_overrun`=1; ack in the same cycle as a completion → `inpr`=new byte, `fgi`=1, no overrun.
5. Errors: a start glitch of 4 cycles → no frame; stop bit driven low → `frame_err` pulse, `fgi` unchanged; with `IO_SERIAL_PARITY_EN`, a wrong parity on 0x07 → `parity_err` pulse, byte dropped.
6. Reset mid-transmit: assert RST_N=0 at cycle 50 of a frame → `tx`=1 and `fgo`=1 after the reset edge; a subsequent load transmits normally.

Source files
------------

// File: rtl/io_serial_pkg.sv
// Shared state types and reset constants for io_serial_port.
// IO_SERIAL_PARITY_EN adds the even-parity states to both FSMs.
package io_serial_pkg;

`ifdef IO_SERIAL_PARITY_EN
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

  localparam int unsigned IO_STOP_BITS = 1;
  localparam logic        FGO_RST      = 1'b1;
  localparam logic        FGI_RST      = 1'b0;

endpackage

// File: rtl/io_serial_port_bit_timer.sv
// io_bit_timer: free-running bit-period down-counter; start reloads it with
// a half or full period, tick marks the last cycle of each period.
module io_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic half,
  output logic tick
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= FULL_M1;
    else if (start)       cnt <= half ? HALF_M1 : FULL_M1;
    else if (cnt == '0)   cnt <= FULL_M1;
    else                  cnt <= cnt - 1'b1;
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/io_serial_port.sv
// io_serial_port: INP/OUT/SKI/SKO serial front-end, 8N1 receiver and transmitter.
// Define IO_SERIAL_PARITY_EN for an even-parity bit after the data bits.
module io_serial_port
  import io_serial_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             rx,
  output logic             tx,
  output logic [WIDTH-1:0] inpr,
  output logic             fgi,
  input  logic             inp_ack,
  input  logic [WIDTH-1:0] outr,
  input  logic             out_load,
  output logic             fgo,
  output logic             rx_overrun,
  output logic             frame_err,
  output logic             parity_err
);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic rx_meta, rx_s, rx_s_d;
  logic rx_start, rx_tick, rx_done, rx_good, par_bad;
  logic tx_load, tx_tick, tx_end, tx_bit;
  logic [WIDTH-1:0] rx_shift, tx_shift;
  logic [IDX_W-1:0] rx_idx, tx_idx;
  rx_state_t rx_state, rx_next;
  tx_state_t tx_state, tx_next;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  io_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk(CLK), .rst_n(RST_N), .start(rx_start), .half(1'b1), .tick(rx_tick)
  );

  io_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk(CLK), .rst_n(RST_N), .start(tx_load), .half(1'b0), .tick(tx_tick)
  );

  // ---------------- receiver ----------------
  always_ff @(posedge CLK) begin
    if (!RST_N) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next  = rx_state;
    rx_start = 1'b0;
    rx_done  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_s_d && !rx_s) begin
                  rx_next  = RX_START;
                  rx_start = 1'b1;
                end
      RX_START: if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
`ifdef IO_SERIAL_PARITY_EN
      RX_DATA:  if (rx_tick && rx_idx == LAST_IDX) rx_next = RX_PARITY;
      RX_PARITY: if (rx_tick) rx_next = RX_STOP;
`else
      RX_DATA:  if (rx_tick && rx_idx == LAST_IDX) rx_next = RX_STOP;
`endif
      RX_STOP:  if (rx_tick) begin
                  rx_next = RX_IDLE;
                  rx_done = 1'b1;
                end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_shift <= '0;
      rx_idx   <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_idx <= '0;
    end else if (rx_state == RX_DATA && rx_tick) begin
      rx_shift <= {rx_s, rx_shift[WIDTH-1:1]};
      rx_idx   <= (rx_idx == LAST_IDX) ? '0 : rx_idx + 1'b1;
    end
  end

`ifdef IO_SERIAL_PARITY_EN
  logic rx_par;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rx_par     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (rx_state == RX_PARITY && rx_tick) rx_par <= rx_s;
      parity_err <= rx_done && rx_s && par_bad;
    end
  end

  assign par_bad = rx_par ^ (^rx_shift);
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign rx_good = rx_done && rx_s && !par_bad;

  // An ack coinciding with a completed byte frees the slot, so the byte loads.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      inpr       <= '0;
      fgi        <= FGI_RST;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= rx_done && !rx_s;
      if (rx_good && (!fgi || inp_ack)) begin
        inpr <= rx_shift;
        fgi  <= 1'b1;
      end else begin
        if (rx_good) rx_overrun <= 1'b1;
        if (inp_ack) fgi <= 1'b0;
      end
    end
  end

  // ---------------- transmitter ----------------
  assign tx_load = out_load && fgo;

`ifdef IO_SERIAL_PARITY_EN
  logic tx_par;

  always_ff @(posedge CLK) begin
    if (!RST_N)       tx_par <= 1'b0;
    else if (tx_load) tx_par <= ^outr;
  end
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    tx_end  = 1'b0;
    tx_bit  = 1'b1;
    case (tx_state)
      TX_IDLE:  if (tx_load) tx_next = TX_START;
      TX_START: begin
        tx_bit = 1'b0;
        if (tx_tick) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_bit = tx_shift[0];
`ifdef IO_SERIAL_PARITY_EN
        if (tx_tick && tx_idx == LAST_IDX) tx_next = TX_PARITY;
      end
      TX_PARITY: begin
        tx_bit = tx_par;
        if (tx_tick) tx_next = TX_STOP;
`else
        if (tx_tick && tx_idx == LAST_IDX) tx_next = TX_STOP;
`endif
      end
      TX_STOP:  if (tx_tick) begin
                  tx_next = TX_IDLE;
                  tx_end  = 1'b1;
                end
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      tx       <= 1'b1;
      fgo      <= FGO_RST;
      tx_shift <= '0;
      tx_idx   <= '0;
    end else begin
      tx <= tx_bit;
      if (tx_load) begin
        fgo      <= 1'b0;
        tx_shift <= outr;
        tx_idx   <= '0;
      end else begin
        if (tx_end) fgo <= 1'b1;
        if (tx_state == TX_DATA && tx_tick) begin
          tx_shift <= {1'b0, tx_shift[WIDTH-1:1]};
          tx_idx   <= (tx_idx == LAST_IDX) ? '0 : tx_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_io_serial_port.sv
// Self-checking bench for io_serial_port: randomized frames checked against
// a bit-level serial-line model built from frame arithmetic.
module tb_io_serial_port;
  localparam int W   = 8;
  localparam int CPB = 16;
`ifdef IO_SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB       = W + 2 + PAR;
  localparam int FGO_T    = NB * CPB;
  localparam int RX_T     = 2 + CPB / 2 + (NB - 1) * CPB + 1;
  localparam int PLAY_LEN = NB * CPB + 8;

  logic CLK, RST_N, rx, tx, fgi, inp_ack, out_load, fgo;
  logic rx_overrun, frame_err, parity_err;
  logic [W-1:0] inpr, outr;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_byte;

  logic       r_fgi  [0:255];
  logic [7:0] r_inpr [0:255];
  logic       r_ferr [0:255];
  logic       r_perr [0:255];
  logic       r_ovr  [0:255];

  io_serial_port #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST_N(RST_N), .rx(rx), .tx(tx), .inpr(inpr), .fgi(fgi),
    .inp_ack(inp_ack), .outr(outr), .out_load(out_load), .fgo(fgo),
    .rx_overrun(rx_overrun), .frame_err(frame_err), .parity_err(parity_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  // Line level of bit slot b of a frame: start, data LSB first, [parity], stop, idle.
  function automatic logic frame_bit(input logic [7:0] d, input int b,
                                     input logic stop_v, input logic par_flip);
    logic [7:0] sh;
    if (b == 0) return 1'b0;
    if (b <= W) begin
      sh = d >> (b - 1);
      return sh[0];
    end
    if (PAR == 1 && b == W + 1) return (^d) ^ par_flip;
    if (b == NB - 1) return stop_v;
    return 1'b1;
  endfunction

  // tx level k cycles after the capture edge (line is one cycle behind).
  function automatic logic exp_tx(input logic [7:0] d, input int k);
    if (k < 1) return 1'b1;
    return frame_bit(d, (k - 1) / CPB, 1'b1, 1'b0);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic play_rx(input logic [7:0] d, input logic stop_v, input logic par_flip,
                         input int ack_at);
    for (int k = 0; k < PLAY_LEN; k++) begin
      step();
      r_fgi[k]  = fgi;
      r_inpr[k] = inpr;
      r_ferr[k] = frame_err;
      r_perr[k] = parity_err;
      r_ovr[k]  = rx_overrun;
      rx        = frame_bit(d, k / CPB, stop_v, par_flip);
      inp_ack   = (k == ack_at);
    end
    rx      = 1'b1;
    inp_ack = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) step();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (fgo !== 1'b1) begin errors++; $display("FAIL reset_fgo: got %b expected 1", fgo); end
    checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL reset_fgi: got %b expected 0", fgi); end
    checks++; if (inpr !== 8'h00) begin errors++; $display("FAIL reset_inpr: got %h expected 00", inpr); end
    checks++; if ({rx_overrun, frame_err, parity_err} !== 3'b000) begin
      errors++; $display("FAIL reset_errs: got %b expected 000", {rx_overrun, frame_err, parity_err});
    end
    RST_N = 1'b1;
    last_byte = 8'h00;
  endtask

  task automatic test_transmit(input logic [7:0] d);
    step();
    outr = d; out_load = 1'b1;
    step();
    out_load = 1'b0;
    checks++; if (fgo !== 1'b0) begin errors++; $display("FAIL tx_fgo_drop: got %b expected 0", fgo); end
    for (int k = 1; k <= FGO_T + 2; k++) begin
      step();
      if ((k - 1) % CPB == 0 || (k - 1) % CPB == CPB - 1 || k > FGO_T) begin
        checks++;
        if (tx !== exp_tx(d, k)) begin
          errors++; $display("FAIL tx_bit data=%h cycle=%0d: got %b expected %b", d, k, tx, exp_tx(d, k));
        end
      end
      if (k == FGO_T - 1 || k == FGO_T) begin
        checks++;
        if (fgo !== logic'(k == FGO_T)) begin
          errors++; $display("FAIL tx_fgo_rise cycle=%0d: got %b expected %b", k, fgo, k == FGO_T);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b, junk;
    int rise;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    junk = ~a;
    rise = -1;
    step();
    outr = a; out_load = 1'b1;
    step();
    out_load = 1'b0;
    for (int k = 1; k <= FGO_T + CPB; k++) begin
      step();
      if (k == 30) begin outr = junk; out_load = 1'b1; end
      if (k == 31) out_load = 1'b0;
      if ((k - 1) % CPB == 0 || (k - 1) % CPB == CPB - 1) begin
        checks++;
        if (tx !== exp_tx(a, k)) begin
          errors++; $display("FAIL b2b_first_bit cycle=%0d: got %b expected %b", k, tx, exp_tx(a, k));
        end
      end
      if (fgo) begin rise = k; break; end
    end
    checks++;
    if (rise != FGO_T) begin errors++; $display("FAIL b2b_fgo_rise: got %0d expected %0d", rise, FGO_T); end
    if (rise > 0) begin
      outr = b; out_load = 1'b1;
      step();
      out_load = 1'b0;
      checks++; if (fgo !== 1'b0) begin errors++; $display("FAIL b2b_fgo_drop: got %b expected 0", fgo); end
      for (int j = 1; j <= FGO_T + CPB; j++) begin
        step();
        if ((j - 1) % CPB == 0 || (j - 1) % CPB == CPB - 1 || j > FGO_T) begin
          checks++;
          if (tx !== exp_tx(b, j)) begin
            errors++; $display("FAIL b2b_second_bit cycle=%0d: got %b expected %b", j, tx, exp_tx(b, j));
          end
        end
      end
    end
  endtask

  task automatic test_receive(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom_range(0, 255));
      play_rx(d, 1'b1, 1'b0, -1);
      checks++; if (r_fgi[RX_T-1] !== 1'b0) begin errors++; $display("FAIL rx_fgi_early: got %b expected 0", r_fgi[RX_T-1]); end
      checks++; if (r_fgi[RX_T] !== 1'b1) begin errors++; $display("FAIL rx_fgi_rise: got %b expected 1", r_fgi[RX_T]); end
      checks++; if (r_inpr[RX_T] !== d) begin errors++; $display("FAIL rx_inpr: got %h expected %h", r_inpr[RX_T], d); end
      checks++; if (r_ferr[RX_T] !== 1'b0 || r_perr[RX_T] !== 1'b0) begin
        errors++; $display("FAIL rx_no_err: got %b%b expected 00", r_ferr[RX_T], r_perr[RX_T]);
      end
      inp_ack = 1'b1;
      step();
      inp_ack = 1'b0;
      checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL rx_ack_clear: got %b expected 0", fgi); end
      checks++; if (inpr !== d) begin errors++; $display("FAIL rx_inpr_hold: got %h expected %h", inpr, d); end
      last_byte = d;
    end
  endtask

  task automatic test_ack_no_effect();
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    step();
    checks++; if (fgi !== 1'b0 || inpr !== last_byte) begin
      errors++; $display("FAIL ack_idle: got fgi=%b inpr=%h expected fgi=0 inpr=%h", fgi, inpr, last_byte);
    end
  endtask

  task automatic test_ack_collision();
    logic [7:0] x, y;
    x = 8'($urandom_range(0, 255));
    y = x ^ 8'($urandom_range(1, 255));
    play_rx(x, 1'b1, 1'b0, -1);
    checks++; if (r_inpr[RX_T] !== x || r_fgi[RX_T] !== 1'b1) begin
      errors++; $display("FAIL coll_first: got inpr=%h fgi=%b expected inpr=%h fgi=1", r_inpr[RX_T], r_fgi[RX_T], x);
    end
    play_rx(y, 1'b1, 1'b0, RX_T - 1);
    checks++; if (r_inpr[RX_T] !== y) begin errors++; $display("FAIL coll_inpr: got %h expected %h", r_inpr[RX_T], y); end
    checks++; if (r_fgi[RX_T] !== 1'b1 || r_fgi[RX_T+2] !== 1'b1) begin
      errors++; $display("FAIL coll_fgi: got %b%b expected 11", r_fgi[RX_T], r_fgi[RX_T+2]);
    end
    checks++; if (r_ovr[RX_T+2] !== 1'b0) begin errors++; $display("FAIL coll_overrun: got %b expected 0", r_ovr[RX_T+2]); end
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    checks++; if (fgi !== 1'b0) begin errors++; $display("FAIL coll_ack_clear: got %b expected 0", fgi); end
    last_byte = y;
  endtask

  task automatic test_overrun();
    play_rx(8'h11, 1'b1, 1'b0, -1);
    checks++; if (r_inpr[RX_T] !== 8'h11 || r_ovr[RX_T] !== 1'b0) begin
      errors++; $display("FAIL ovr_first: got inpr=%h ovr=%b expected inpr=11 ovr=0", r_inpr[RX_T], r_ovr[RX_T]);
    end
    play_rx(8'h22, 1'b1, 1'b0, -1);
    checks++; if (r_inpr[RX_T] !== 8'h11) begin errors++; $display("FAIL ovr_inpr_kept: got %h expected 11", r_inpr[RX_T]); end
    checks++; if (r_ovr[RX_T-1] !== 1'b0 || r_ovr[RX_T] !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b%b expected 01", r_ovr[RX_T-1], r_ovr[RX_T]);
    end
    checks++; if (r_fgi[RX_T] !== 1'b1) begin errors++; $display("FAIL ovr_fgi: got %b expected 1", r_fgi[RX_T]); end
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    step();
    checks++; if (fgi !== 1'b0 || rx_overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got fgi=%b ovr=%b expected fgi=0 ovr=1", fgi, rx_overrun);
    end
    last_byte = 8'h11;
  endtask

  task automatic test_glitch();
    logic bad;
    logic [7:0] d;
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      step();
      rx = (k < 4) ? 1'b0 : 1'b1;
      if (fgi || frame_err || parity_err) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0 || inpr !== last_byte) begin
      errors++; $display("FAIL glitch_no_frame: got bad=%b inpr=%h expected bad=0 inpr=%h", bad, inpr, last_byte);
    end
    d = 8'($urandom_range(0, 255));
    play_rx(d, 1'b1, 1'b0, -1);
    checks++; if (r_inpr[RX_T] !== d || r_fgi[RX_T] !== 1'b1) begin
      errors++; $display("FAIL glitch_recover: got inpr=%h fgi=%b expected inpr=%h fgi=1", r_inpr[RX_T], r_fgi[RX_T], d);
    end
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    last_byte = d;
  endtask

  task automatic test_frame_error();
    logic [7:0] d;
    d = ~last_byte;
    play_rx(d, 1'b0, 1'b0, -1);
    checks++; if ({r_ferr[RX_T-1], r_ferr[RX_T], r_ferr[RX_T+1]} !== 3'b010) begin
      errors++; $display("FAIL ferr_pulse: got %b%b%b expected 010", r_ferr[RX_T-1], r_ferr[RX_T], r_ferr[RX_T+1]);
    end
    checks++; if (r_fgi[RX_T+1] !== 1'b0 || r_inpr[RX_T+1] !== last_byte) begin
      errors++; $display("FAIL ferr_discard: got fgi=%b inpr=%h expected fgi=0 inpr=%h", r_fgi[RX_T+1], r_inpr[RX_T+1], last_byte);
    end
  endtask

  task automatic test_parity();
`ifdef IO_SERIAL_PARITY_EN
    play_rx(8'h07, 1'b1, 1'b1, -1);
    checks++; if ({r_perr[RX_T-1], r_perr[RX_T], r_perr[RX_T+1]} !== 3'b010) begin
      errors++; $display("FAIL perr_pulse: got %b%b%b expected 010", r_perr[RX_T-1], r_perr[RX_T], r_perr[RX_T+1]);
    end
    checks++; if (r_fgi[RX_T+1] !== 1'b0 || r_inpr[RX_T+1] !== last_byte || r_ferr[RX_T] !== 1'b0) begin
      errors++; $display("FAIL perr_discard: got fgi=%b inpr=%h ferr=%b expected fgi=0 inpr=%h ferr=0",
                         r_fgi[RX_T+1], r_inpr[RX_T+1], r_ferr[RX_T], last_byte);
    end
`else
    logic any;
    any = 1'b0;
    play_rx(8'h07, 1'b1, 1'b0, -1);
    for (int k = 0; k < PLAY_LEN; k++) if (r_perr[k] !== 1'b0) any = 1'b1;
    checks++; if (any !== 1'b0 || r_inpr[RX_T] !== 8'h07) begin
      errors++; $display("FAIL perr_tied: got perr=%b inpr=%h expected perr=0 inpr=07", any, r_inpr[RX_T]);
    end
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    last_byte = 8'h07;
`endif
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255)) & 8'hFB;
    step();
    outr = d; out_load = 1'b1;
    step();
    out_load = 1'b0;
    for (int k = 1; k <= 50; k++) step();
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midtx_pre: got %b expected 0", tx); end
    RST_N = 1'b0;
    step();
    checks++; if (tx !== 1'b1 || fgo !== 1'b1) begin
      errors++; $display("FAIL midtx_reset: got tx=%b fgo=%b expected tx=1 fgo=1", tx, fgo);
    end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL midtx_ovr_clear: got %b expected 0", rx_overrun); end
    RST_N = 1'b1;
    test_transmit(8'($urandom_range(0, 255)));
  endtask

  initial begin
    RST_N = 1'b0; rx = 1'b1; inp_ack = 1'b0; out_load = 1'b0; outr = '0;
    last_byte = 8'h00;
    test_reset();
    test_transmit(8'hA5);
    test_transmit(8'($urandom_range(0, 255)));
    test_transmit(8'($urandom_range(0, 255)));
    test_back_to_back();
    play_rx(8'h3C, 1'b1, 1'b0, -1);
    checks++; if (r_inpr[RX_T] !== 8'h3C || r_fgi[RX_T] !== 1'b1 || r_fgi[RX_T-1] !== 1'b0) begin
      errors++; $display("FAIL rx_3c: got inpr=%h fgi=%b%b expected inpr=3c fgi=01", r_inpr[RX_T], r_fgi[RX_T-1], r_fgi[RX_T]);
    end
    inp_ack = 1'b1;
    step();
    inp_ack = 1'b0;
    checks++; if (fgi !== 1'b0 || inpr !== 8'h3C) begin
      errors++; $display("FAIL rx_3c_ack: got fgi=%b inpr=%h expected fgi=0 inpr=3c", fgi, inpr);
    end
    last_byte = 8'h3C;
    test_receive(3);
    test_ack_no_effect();
    test_ack_collision();
    test_overrun();
    test_glitch();
    test_frame_error();
    test_parity();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
